// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the instruction-fetch PC logic.
//  - INST_ADDR_W : width of an instruction address
//  - STALL_W     : width of the pipeline stall vector (bit 0 belongs to IF)
//  - STOP        : value of a stall bit that freezes its stage
//  - fetch_state_e : fetch sequencer states (idle after reset, running, holding
//                    a redirect behind a stall)
//  - seq_next_pc : sequential PC advance; wraps modulo 2^INST_ADDR_W
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

    localparam int   INST_ADDR_W  = 32;
    localparam int   STALL_W      = 6;
    localparam logic STOP         = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Plain unsigned add: carry out of the top bit is dropped, so the PC wraps
    // to zero instead of trapping.
    function automatic logic [INST_ADDR_W-1:0] seq_next_pc(
        input logic [INST_ADDR_W-1:0] pc,
        input logic [INST_ADDR_W-1:0] step
    );
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_redirect_hold.sv
// -----------------------------------------------------------------------------
// fetch_redirect_hold
// Parks one redirect target until the consumer is ready to apply it. The first
// target captured wins; later set requests are ignored while one is parked.
// Ports:
//  clk      in   rising-edge clock
//  rst      in   synchronous, active-high; drops any parked target
//  set_i    in   capture target_i (ignored while valid_o is already high)
//  target_i in   target to capture
//  clear_i  in   the parked target has been consumed
//  flush_i  in   discard the parked target (takes precedence over set_i)
//  valid_o  out  a target is parked
//  target_o out  the parked target
// -----------------------------------------------------------------------------
module fetch_redirect_hold #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              clear_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // Clearing and flushing both win over a new capture; a capture only lands
    // when nothing is parked so the oldest redirect is the one that survives.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (flush_i || clear_i) begin
            valid_d = 1'b0;
        end else if (set_i && !valid_q) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end
    end

    // Storage for the parked target and its valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Front of the IF->ID path: owns the PC and the request to the synchronous
// instruction ROM (one-cycle read latency). Applies stalls, branch redirects
// from ID and exception redirects from ctrl; a branch that arrives while IF is
// stalled is parked and applied when the stall releases.
// Ports:
//  clk             in   rising-edge clock
//  rst             in   synchronous, active-high
//  stall           in   pipeline stall vector; stall[0] == STOP freezes the PC
//  flush           in   exception flush; beats stall and branches
//  new_pc          in   exception target, valid with flush
//  branch_flag_i   in   taken branch/jump resolved in ID
//  branch_target_i in   branch target, valid with branch_flag_i
//  rom_ce          out  ROM chip enable
//  if_pc           out  address presented to the ROM this cycle
//  squash_o        out  instruction now returning from the ROM is wrong-path
//  redirect_pend_o out  a branch target is parked behind a stall
// Configuration:
//  BRANCH_DELAY_SLOT_EN defined   : delay-slot instruction is kept, squash_o = 0
//  BRANCH_DELAY_SLOT_EN undefined : every applied redirect pulses squash_o once
// -----------------------------------------------------------------------------
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic                   squash_o,
    output logic                   redirect_pend_o
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   stall_stop;
    logic                   pend_set;
    logic                   pend_clear;
    logic                   pend_valid;
    logic [INST_ADDR_W-1:0] pend_target;
    logic                   redirect_taken;
    logic                   unused_stall;

    // Only the IF bit of the stall vector matters here.
    assign stall_stop   = (stall[0] == STOP);
    assign unused_stall = ^stall[STALL_W-1:1];

    fetch_redirect_hold #(
        .ADDR_W (INST_ADDR_W)
    ) u_redirect_hold (
        .clk      (clk),
        .rst      (rst),
        .set_i    (pend_set),
        .target_i (branch_target_i),
        .clear_i  (pend_clear),
        .flush_i  (flush),
        .valid_o  (pend_valid),
        .target_o (pend_target)
    );

    // State register: PC and sequencer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic. S_IDLE holds the PC for one edge so RESET_PC is fetched
    // exactly once once the ROM is enabled. In S_RUN flush beats stall, which
    // beats a branch; a branch blocked by the stall is parked and S_HOLD waits
    // for the release. In S_HOLD new branches are ignored so the parked target
    // wins, but a flush still overrides it.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_set       = 1'b0;
        pend_clear     = 1'b0;
        redirect_taken = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (flush) begin
                    pc_d           = new_pc;
                    redirect_taken = 1'b1;
                end else if (stall_stop) begin
                    if (branch_flag_i) begin
                        pend_set = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if (branch_flag_i) begin
                    pc_d           = branch_target_i;
                    redirect_taken = 1'b1;
                end else begin
                    pc_d = seq_next_pc(pc_q, PC_STEP);
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d           = new_pc;
                    redirect_taken = 1'b1;
                    state_d        = S_RUN;
                end else if (!stall_stop) begin
                    pc_d           = pend_target;
                    pend_clear     = 1'b1;
                    redirect_taken = 1'b1;
                    state_d        = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic. The ROM stays enabled through stalls; only reset and the
    // single idle cycle after it keep it off.
    always_comb begin
        rom_ce          = (state_q == S_IDLE) ? CHIP_DISABLE : CHIP_ENABLE;
        if_pc           = pc_q;
        redirect_pend_o = pend_valid;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // The instruction behind a branch is a real delay slot, so nothing is
    // ever squashed.
    logic unused_redirect;
    assign unused_redirect = redirect_taken;
    assign squash_o        = 1'b0;
`else
    logic squash_q, squash_d;

    // The instruction fetched from the old PC comes back from the ROM in the
    // cycle after the redirect edge, so a one-cycle registered pulse lines up
    // with it exactly.
    always_comb begin
        squash_d = redirect_taken;
    end

    // Squash pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q <= 1'b0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign squash_o = squash_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
// Drives pc_fetch with directed scenarios followed by random traffic. A
// behavioural model predicts the outputs after every edge and queues them; a
// monitor pops each prediction and compares it with the DUT.
// Honours BRANCH_DELAY_SLOT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        sq;
        logic        pend;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce;
    logic [31:0] if_pc;
    logic        squash_o;
    logic        redirect_pend_o;

    exp_t exp_q[$];
    exp_t mon_exp;

    int check_count;
    int pass_count;

    // Reference model state: kept as "has the first fetch started" and
    // "is a branch target waiting" rather than as an FSM.
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_pending;
    logic [31:0] m_pend_target;
    logic        m_squash;

    pc_fetch #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce          (rom_ce),
        .if_pc           (if_pc),
        .squash_o        (squash_o),
        .redirect_pend_o (redirect_pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model by the
    // edge that follows and queue what the DUT must show after it.
    task automatic applyStimulus(input logic r, input logic [5:0] st, input logic fl,
                                 input logic [31:0] npc, input logic br, input logic [31:0] tgt);
        logic redirect;
        exp_t e;
        @(negedge clk);
        rst             = r;
        stall           = st;
        flush           = fl;
        new_pc          = npc;
        branch_flag_i   = br;
        branch_target_i = tgt;

        redirect = 1'b0;
        if (r) begin
            m_pc      = RESET_PC;
            m_started = 1'b0;
            m_pending = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (fl) begin
            m_pc      = npc;
            m_pending = 1'b0;
            redirect  = 1'b1;
        end else if (m_pending) begin
            if (!st[0]) begin
                m_pc      = m_pend_target;
                m_pending = 1'b0;
                redirect  = 1'b1;
            end
        end else if (st[0]) begin
            if (br) begin
                m_pending     = 1'b1;
                m_pend_target = tgt;
            end
        end else if (br) begin
            m_pc     = tgt;
            redirect = 1'b1;
        end else begin
            m_pc = m_pc + PC_STEP;
        end
`ifdef BRANCH_DELAY_SLOT_EN
        m_squash = 1'b0;
`else
        m_squash = r ? 1'b0 : redirect;
`endif
        e.pc   = m_pc;
        e.ce   = m_started;
        e.sq   = m_squash;
        e.pend = m_pending;
        exp_q.push_back(e);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic runStall(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Monitor: one prediction per edge, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checkOutput("if_pc",           if_pc,                    mon_exp.pc);
            checkOutput("rom_ce",          {31'd0, rom_ce},          {31'd0, mon_exp.ce});
            checkOutput("squash_o",        {31'd0, squash_o},        {31'd0, mon_exp.sq});
            checkOutput("redirect_pend_o", {31'd0, redirect_pend_o}, {31'd0, mon_exp.pend});
        end
    end

    initial begin
        logic        r_rst;
        logic [5:0]  r_stall;
        logic        r_flush;
        logic        r_br;
        logic [31:0] r_npc;
        logic [31:0] r_tgt;

        check_count     = 0;
        pass_count      = 0;
        m_pc            = RESET_PC;
        m_started       = 1'b0;
        m_pending       = 1'b0;
        m_pend_target   = 32'd0;
        m_squash        = 1'b0;
        rst             = 1'b1;
        stall           = 6'd0;
        flush           = 1'b0;
        new_pc          = 32'd0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;

        $display("[TB] reset and sequential fetch");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        runIdle(5);

        $display("[TB] stall at 0x10 then release");
        runStall(4);
        runIdle(4);

        $display("[TB] branch to 0x100");
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0100);
        runIdle(2);

        $display("[TB] branch to 0x200 under stall");
        applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 32'h0000_0200);
        runStall(3);
        runIdle(2);

        $display("[TB] flush with branch and stall");
        applyStimulus(1'b0, 6'b000001, 1'b1, 32'h8000_0180, 1'b1, 32'h0000_0300);
        runIdle(2);

        $display("[TB] flush while a target is parked");
        applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 32'h0000_0400);
        runStall(1);
        applyStimulus(1'b0, 6'b000001, 1'b1, 32'h8000_0200, 1'b0, 32'd0);
        runStall(1);
        runIdle(2);

        $display("[TB] second branch while holding is ignored");
        applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 32'h0000_0600);
        applyStimulus(1'b0, 6'b000011, 1'b0, 32'd0, 1'b1, 32'h0000_0700);
        applyStimulus(1'b0, 6'd0,      1'b0, 32'd0, 1'b1, 32'h0000_0800);
        runIdle(2);

        $display("[TB] PC wrap");
        applyStimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        runIdle(2);

        $display("[TB] reset while holding");
        applyStimulus(1'b0, 6'b000001, 1'b0, 32'd0, 1'b1, 32'h0000_0500);
        runStall(1);
        applyStimulus(1'b1, 6'b000001, 1'b0, 32'd0, 1'b0, 32'd0);
        runIdle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            r_rst   = ($urandom_range(0, 99) < 2);
            r_stall = 6'($urandom);
            r_stall[0] = ($urandom_range(0, 99) < 30);
            r_flush = ($urandom_range(0, 99) < 5);
            r_br    = ($urandom_range(0, 99) < 20);
            r_npc   = $urandom & 32'hFFFF_FFFC;
            r_tgt   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(r_rst, r_stall, r_flush, r_npc, r_br, r_tgt);
        end

        repeat (2) @(posedge clk);
        #3;
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
